// File: rtl/psum_accum_pkg.sv
// psum_accum shared types: FSM encoding and lane
// saturation limits for the default psum width.
package psum_accum_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int PSUM_BW = 16;

  localparam logic signed [PSUM_BW-1:0] SAT_MAX =
    {1'b0, {(PSUM_BW-1){1'b1}}};
  localparam logic signed [PSUM_BW-1:0] SAT_MIN =
    {1'b1, {(PSUM_BW-1){1'b0}}};

endpackage

// File: rtl/psum_lane_sat_add.sv
// One lane: saturating accumulate (or first-kij load)
// plus an independent ReLU path for the drain side.
module psum_lane_sat_add
  import psum_accum_pkg::*;
#(
  parameter int psum_bw = PSUM_BW
) (
  input  logic signed [psum_bw-1:0] acc,
  input  logic signed [psum_bw-1:0] din,
  input  logic                      first,
  input  logic signed [psum_bw-1:0] dv,
  input  logic                      relu,
  output logic signed [psum_bw-1:0] sum,
  output logic signed [psum_bw-1:0] act
);

  localparam logic signed [psum_bw-1:0] MAXV =
    (psum_bw == PSUM_BW) ? SAT_MAX
                         : {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic signed [psum_bw-1:0] MINV =
    (psum_bw == PSUM_BW) ? SAT_MIN
                         : {1'b1, {(psum_bw-1){1'b0}}};

  logic signed [psum_bw:0] wide;

  assign wide = {acc[psum_bw-1], acc}
              + {din[psum_bw-1], din};

  // one extra bit: top two bits differ only on overflow
  always_comb begin
    sum = wide[psum_bw-1:0];
    if (first)
      sum = din;
    else if (wide[psum_bw] != wide[psum_bw-1])
      sum = wide[psum_bw] ? MINV : MAXV;
  end

  assign act = (relu && dv[psum_bw-1]) ? '0 : dv;

endmodule

// File: rtl/psum_accum.sv
// Pops ofifo words, accumulates them across kij into a
// local buffer, then drains the sums one row per cycle.
module psum_accum
  import psum_accum_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int col     = 8,
  parameter int depth   = 16,
  parameter int aw      = 4,
  parameter int kw      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [aw:0]            num_o,
  input  logic [kw-1:0]          num_kij,
  input  logic                   relu_en,
  input  logic [col*psum_bw-1:0] in_psum,
  input  logic                   in_valid,
  output logic                   rd_ofifo,
  output logic [col*psum_bw-1:0] out_psum,
  output logic [aw-1:0]          out_addr,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   done
);

  state_t               state;
  logic [aw:0]          num_o_q;
  logic [kw-1:0]        num_kij_q;
  logic                 relu_q;
  logic [aw-1:0]        o_cnt;
  logic [kw-1:0]        k_cnt;
  logic [aw-1:0]        p;
  logic [col*psum_bw-1:0] mem [depth];

  logic [col*psum_bw-1:0] rd_word;
  logic [col*psum_bw-1:0] dr_word;
  logic [col*psum_bw-1:0] sum_w;
  logic [col*psum_bw-1:0] act_w;
  logic                   pop;
  logic                   last_o;
  logic                   last_k;
  logic                   last_p;

  assign pop      = (state == S_ACCUM) && in_valid;
  assign rd_ofifo = pop;
  assign busy     = (state != S_IDLE);

  assign rd_word = mem[o_cnt];
  assign dr_word = mem[p];

  assign last_o = ({1'b0, o_cnt} == num_o_q - 1'b1);
  assign last_k = (k_cnt == num_kij_q - 1'b1);
  assign last_p = ({1'b0, p} == num_o_q - 1'b1);

  for (genvar g = 0; g < col; g++) begin : g_lane
    psum_lane_sat_add #(
      .psum_bw(psum_bw)
    ) u_lane (
      .acc  (rd_word[g*psum_bw +: psum_bw]),
      .din  (in_psum[g*psum_bw +: psum_bw]),
      .first(k_cnt == '0),
      .dv   (dr_word[g*psum_bw +: psum_bw]),
      .relu (relu_q),
      .sum  (sum_w[g*psum_bw +: psum_bw]),
      .act  (act_w[g*psum_bw +: psum_bw])
    );
  end

  // buffer is left uncleared; the kij==0 pass loads it
  always_ff @(posedge clk) begin
    if (pop)
      mem[o_cnt] <= sum_w;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      num_o_q   <= '0;
      num_kij_q <= '0;
      relu_q    <= 1'b0;
      o_cnt     <= '0;
      k_cnt     <= '0;
      p         <= '0;
      out_psum  <= '0;
      out_addr  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= (state == S_DONE);
      unique case (state)
        S_IDLE: begin
          if (start) begin
            num_o_q   <= num_o;
            num_kij_q <= num_kij;
            relu_q    <= relu_en;
            o_cnt     <= '0;
            k_cnt     <= '0;
            p         <= '0;
            if (num_o == '0 || num_kij == '0)
              state <= S_DONE;
            else
              state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (pop) begin
            if (last_o) begin
              o_cnt <= '0;
              if (last_k) begin
                k_cnt <= '0;
                state <= S_DRAIN;
              end else begin
                k_cnt <= k_cnt + 1'b1;
              end
            end else begin
              o_cnt <= o_cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          out_valid <= 1'b1;
          out_addr  <= p;
          out_psum  <= act_w;
          if (last_p) begin
            p     <= '0;
            state <= S_DONE;
          end else begin
            p <= p + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accum.sv
// Randomized bench for psum_accum against an integer
// accumulate / clamp / ReLU model.
module tb_psum_accum;

  localparam int W  = 16;
  localparam int C  = 8;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam int KW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [AW:0]     num_o = '0;
  logic [KW-1:0]   num_kij = '0;
  logic            relu_en = 1'b0;
  logic [C*W-1:0]  in_psum = '0;
  logic            in_valid = 1'b0;
  logic            rd_ofifo;
  logic [C*W-1:0]  out_psum;
  logic [AW-1:0]   out_addr;
  logic            out_valid;
  logic            busy;
  logic            done;

  psum_accum dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .num_o    (num_o),
    .num_kij  (num_kij),
    .relu_en  (relu_en),
    .in_psum  (in_psum),
    .in_valid (in_valid),
    .rd_ofifo (rd_ofifo),
    .out_psum (out_psum),
    .out_addr (out_addr),
    .out_valid(out_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int             wl [256][C];
  logic [C*W-1:0] exp_w [D];
  logic [C*W-1:0] got_w [D];
  int             got_addr [D];
  int nbeats, npops, rd_err, busy_drop;
  int done_at, first_ov_at, last_pop_at;
  bit done_seen;

  function automatic int clamp(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // word for output o at kernel position k is wl[k*no+o]
  function automatic void model(int no, int nk, bit relu);
    int acc [D][C];
    int r;
    logic [W-1:0] b;
    for (int k = 0; k < nk; k++)
      for (int o = 0; o < no; o++)
        for (int l = 0; l < C; l++)
          acc[o][l] = (k == 0) ? wl[k*no+o][l]
                    : clamp(acc[o][l] + wl[k*no+o][l]);
    for (int o = 0; o < D; o++) begin
      exp_w[o] = '0;
      if (o < no)
        for (int l = 0; l < C; l++) begin
          r = (relu && acc[o][l] < 0) ? 0 : acc[o][l];
          b = r[W-1:0];
          exp_w[o][l*W +: W] = b;
        end
    end
  endfunction

  function automatic void fill(int mode, int c);
    for (int i = 0; i < 256; i++)
      for (int l = 0; l < C; l++)
        case (mode)
          0: wl[i][l] = c;
          1: wl[i][l] = int'($urandom_range(65535)) - 32768;
          default: wl[i][l] = int'($urandom_range(2000)) - 1000;
        endcase
  endfunction

  function automatic logic [C*W-1:0] pack(int idx);
    logic [C*W-1:0] w;
    int v;
    logic [W-1:0] b;
    w = '0;
    if (idx < 256)
      for (int l = 0; l < C; l++) begin
        v = wl[idx][l];
        b = v[W-1:0];
        w[l*W +: W] = b;
      end
    return w;
  endfunction

  function automatic int lane(logic [C*W-1:0] w, int l);
    logic signed [W-1:0] s;
    s = w[l*W +: W];
    return int'(s);
  endfunction

  // drives one tile and records what the DUT did
  task automatic run_tile(int no, int nk, bit relu,
                          int vpct, int restart_at);
    int n, ptr, limit;
    logic exp_rd;
    n = no * nk;
    ptr = 0;
    nbeats = 0; npops = 0; rd_err = 0; busy_drop = 0;
    done_at = -1; first_ov_at = -1; last_pop_at = -1;
    done_seen = 0;
    limit = 8 * (n + no) + 40;
    for (int i = 0; i < limit && !done_seen; i++) begin
      @(negedge clk);
      start = (i == 0) || (restart_at > 0 && i == restart_at);
      if (i == 0) begin
        num_o = no[AW:0];
        num_kij = nk[KW-1:0];
        relu_en = relu;
      end else if (start) begin
        num_o = 1;
        num_kij = 1;
        relu_en = ~relu;
      end
      in_valid = ($urandom_range(99) < vpct);
      in_psum = pack(ptr);
      #1;
      exp_rd = (i >= 1 && npops < n) ? in_valid : 1'b0;
      if (rd_ofifo !== exp_rd) rd_err++;
      if (rd_ofifo && in_valid) begin
        npops++;
        ptr++;
        last_pop_at = i;
      end
      if (i >= 1 && busy !== 1'b1 && done !== 1'b1)
        busy_drop++;
      if (out_valid) begin
        if (nbeats < D) begin
          got_w[nbeats] = out_psum;
          got_addr[nbeats] = int'(out_addr);
        end
        nbeats++;
        if (first_ov_at < 0) first_ov_at = i;
      end
      if (done) begin
        done_seen = 1;
        done_at = i;
      end
    end
    @(negedge clk);
    start = 0;
    in_valid = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    in_valid = 1;
    #13;
    total++;
    if (busy !== 0 || out_valid !== 0 || done !== 0) begin
      bad++;
      $display("FAIL reset_flags: got busy=%b ov=%b done=%b want 0 0 0",
               busy, out_valid, done);
    end
    total++;
    if (rd_ofifo !== 0) begin
      bad++;
      $display("FAIL reset_rd: got %b want 0", rd_ofifo);
    end
    total++;
    if (out_psum !== '0 || out_addr !== '0) begin
      bad++;
      $display("FAIL reset_out: got addr=%0d data=%h want 0 0",
               out_addr, out_psum);
    end
    @(negedge clk);
    in_valid = 0;
    reset = 1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    fill(0, 5);
    run_tile(4, 3, 0, 100, 0);
    model(4, 3, 0);
    total++;
    if (!done_seen || npops !== 12 || nbeats !== 4) begin
      bad++;
      $display("FAIL basic_counts: got done=%0d pops=%0d beats=%0d want 1 12 4",
               done_seen, npops, nbeats);
    end
    total++;
    if (first_ov_at !== last_pop_at + 2) begin
      bad++;
      $display("FAIL basic_latency: got first_ov=%0d want %0d",
               first_ov_at, last_pop_at + 2);
    end
    total++;
    if (rd_err !== 0) begin
      bad++;
      $display("FAIL basic_rd: got %0d errors want 0", rd_err);
    end
    total++;
    if (lane(got_w[3], 7) !== 15) begin
      bad++;
      $display("FAIL basic_lane: got %0d want 15", lane(got_w[3], 7));
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got_w[i] !== exp_w[i] || got_addr[i] !== i) begin
        bad++;
        $display("FAIL basic_beat%0d: got addr=%0d data=%h want addr=%0d data=%h",
                 i, got_addr[i], got_w[i], i, exp_w[i]);
      end
    end
  endtask

  task automatic test_relu();
    fill(2, 0);
    for (int i = 0; i < 4; i++) begin
      wl[i][0] = (i < 2) ? -7 : 3;
      wl[i][1] = 4;
    end
    for (int r = 1; r >= 0; r--) begin
      run_tile(2, 2, r[0], 100, 0);
      model(2, 2, r[0]);
      total++;
      if (lane(got_w[0], 0) !== (r ? 0 : -4) ||
          lane(got_w[0], 1) !== 8) begin
        bad++;
        $display("FAIL relu%0d_lanes: got %0d,%0d want %0d,8", r,
                 lane(got_w[0], 0), lane(got_w[0], 1), r ? 0 : -4);
      end
      for (int i = 0; i < 2; i++) begin
        total++;
        if (nbeats !== 2 || got_w[i] !== exp_w[i] || got_addr[i] !== i) begin
          bad++;
          $display("FAIL relu%0d_beat%0d: got beats=%0d addr=%0d data=%h want 2 %0d %h",
                   r, i, nbeats, got_addr[i], got_w[i], i, exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_sat();
    for (int s = 0; s < 2; s++) begin
      fill(0, s ? -20000 : 20000);
      run_tile(1, 3, 0, 100, 0);
      total++;
      if (nbeats !== 1 ||
          lane(got_w[0], 4) !== (s ? -32768 : 32767)) begin
        bad++;
        $display("FAIL sat%0d: got beats=%0d lane=%0d want 1 %0d",
                 s, nbeats, lane(got_w[0], 4), s ? -32768 : 32767);
      end
    end
    fill(1, 0);
    run_tile(1, 5, 1, 60, 0);
    model(1, 5, 1);
    total++;
    if (nbeats !== 1 || got_w[0] !== exp_w[0]) begin
      bad++;
      $display("FAIL sat_rand: got beats=%0d data=%h want 1 %h",
               nbeats, got_w[0], exp_w[0]);
    end
  endtask

  task automatic test_bursty();
    int no, nk;
    bit r;
    for (int t = 0; t < 4; t++) begin
      no = (t == 0) ? 3 : int'($urandom_range(16, 1));
      nk = (t == 0) ? 2 : int'($urandom_range(4, 1));
      r  = (t == 0) ? 1'b0 : 1'($urandom_range(1));
      fill(t == 1 ? 1 : 2, 0);
      run_tile(no, nk, r, 50, 0);
      model(no, nk, r);
      total++;
      if (!done_seen || rd_err !== 0 || npops !== no*nk || nbeats !== no) begin
        bad++;
        $display("FAIL bursty%0d_flow: got done=%0d rd_err=%0d pops=%0d beats=%0d want 1 0 %0d %0d",
                 t, done_seen, rd_err, npops, nbeats, no*nk, no);
      end
      for (int i = 0; i < no; i++) begin
        total++;
        if (got_w[i] !== exp_w[i] || got_addr[i] !== i) begin
          bad++;
          $display("FAIL bursty%0d_beat%0d: got addr=%0d data=%h want addr=%0d data=%h",
                   t, i, got_addr[i], got_w[i], i, exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_zero();
    for (int z = 0; z < 2; z++) begin
      run_tile(z ? 0 : 3, z ? 2 : 0, 0, 100, 0);
      total++;
      if (done_at !== 2 || npops !== 0 || nbeats !== 0) begin
        bad++;
        $display("FAIL zero%0d: got done_at=%0d pops=%0d beats=%0d want 2 0 0",
                 z, done_at, npops, nbeats);
      end
    end
  endtask

  task automatic test_ignored_start();
    fill(2, 0);
    run_tile(4, 3, 0, 100, 3);
    model(4, 3, 0);
    total++;
    if (busy_drop !== 0 || npops !== 12 || nbeats !== 4) begin
      bad++;
      $display("FAIL restart_flow: got drops=%0d pops=%0d beats=%0d want 0 12 4",
               busy_drop, npops, nbeats);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got_w[i] !== exp_w[i] || got_addr[i] !== i) begin
        bad++;
        $display("FAIL restart_beat%0d: got addr=%0d data=%h want addr=%0d data=%h",
                 i, got_addr[i], got_w[i], i, exp_w[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int pops;
    pops = 0;
    fill(0, 9);
    @(negedge clk);
    start = 1;
    num_o = 4;
    num_kij = 3;
    relu_en = 0;
    in_valid = 1;
    in_psum = pack(0);
    for (int i = 0; i < 20 && pops < 5; i++) begin
      @(negedge clk);
      start = 0;
      #1;
      if (rd_ofifo) pops++;
    end
    #2;
    reset = 0;
    #1;
    total++;
    if (pops !== 5 || busy !== 0 || out_valid !== 0 ||
        rd_ofifo !== 0 || done !== 0) begin
      bad++;
      $display("FAIL reset_mid: got pops=%0d busy=%b ov=%b rd=%b done=%b want 5 0 0 0 0",
               pops, busy, out_valid, rd_ofifo, done);
    end
    @(negedge clk);
    in_valid = 0;
    reset = 1;
    fill(0, 1);
    run_tile(2, 2, 0, 100, 0);
    model(2, 2, 0);
    total++;
    if (nbeats !== 2 || lane(got_w[1], 2) !== 2) begin
      bad++;
      $display("FAIL reset_after: got beats=%0d lane=%0d want 2 2",
               nbeats, lane(got_w[1], 2));
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (got_w[i] !== exp_w[i] || got_addr[i] !== i) begin
        bad++;
        $display("FAIL reset_after_beat%0d: got addr=%0d data=%h want addr=%0d data=%h",
                 i, got_addr[i], got_w[i], i, exp_w[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_sat();
    test_bursty();
    test_zero();
    test_ignored_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
